// File: rtl/multi_clock_divider.sv
// Multi-channel runtime-programmable clock divider with shadowed divisor/mode updates.
// Optional build macro MCDIV_SYNC_EN adds a global `sync` input that phase-aligns all channels.
module multi_clock_divider #(
  parameter int          NUM_CH  = 4,
  parameter int          WIDTH   = 32,
  parameter int unsigned N_RESET = 0
) (
  input  logic                      CLOCK,
  input  logic                      RESET_N,
  input  logic [NUM_CH-1:0]         en,
  input  logic [NUM_CH-1:0]         load,
  input  logic [NUM_CH*WIDTH-1:0]   n,
  input  logic [NUM_CH-1:0]         mode,
`ifdef MCDIV_SYNC_EN
  input  logic                      sync,
`endif
  output logic [NUM_CH-1:0]         SLOW_CLOCK,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         pending
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_act_n;
    logic [WIDTH-1:0] r_sh_n;
    logic             r_act_mode;
    logic             r_sh_mode;
    logic             r_pending;
    logic             r_slow;
    logic             r_tick;
    logic             w_wrap;

    // count never exceeds act_n; >= also covers act_n shrinking below a stale count
    assign w_wrap = (r_count >= r_act_n);

    always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
        r_count    <= '0;
        r_act_n    <= WIDTH'(N_RESET);
        r_sh_n     <= WIDTH'(N_RESET);
        r_act_mode <= 1'b0;
        r_sh_mode  <= 1'b0;
        r_pending  <= 1'b0;
        r_slow     <= 1'b0;
        r_tick     <= 1'b0;
      end
`ifdef MCDIV_SYNC_EN
      else if (sync) begin
        r_count <= '0;
        r_slow  <= 1'b0;
        r_tick  <= 1'b0;
        if (r_pending) begin
          r_act_n    <= r_sh_n;
          r_act_mode <= r_sh_mode;
          r_pending  <= 1'b0;
        end
      end
`endif
      else begin
        if (en[k]) begin
          if (w_wrap) begin
            r_count <= '0;
            r_tick  <= 1'b1;
            r_slow  <= r_act_mode ? 1'b1 : ~r_slow;
            if (r_pending) begin
              r_act_n    <= r_sh_n;
              r_act_mode <= r_sh_mode;
              r_pending  <= 1'b0;
            end
          end else begin
            r_count <= r_count + WIDTH'(1);
            r_tick  <= 1'b0;
            if (r_act_mode) r_slow <= 1'b0;
          end
        end else begin
          r_tick <= 1'b0;
          if (r_pending) begin
            r_act_n    <= r_sh_n;
            r_act_mode <= r_sh_mode;
            r_count    <= '0;
            r_pending  <= 1'b0;
            if (r_sh_mode) r_slow <= 1'b0;
          end
        end
        // A load on the applying edge wins the pending flag so the fresh shadow is kept.
        if (load[k]) begin
          r_sh_n    <= n[k*WIDTH +: WIDTH];
          r_sh_mode <= mode[k];
          r_pending <= 1'b1;
        end
      end
    end

    assign SLOW_CLOCK[k] = r_slow;
    assign tick[k]       = r_tick;
    assign pending[k]    = r_pending;
  end

endmodule
